// File: rtl/menu_pkg.sv
// Shared types and constants for the menu subsystem's button front end.
// State encoding for the per-channel debouncer and the channel index map.
package menu_pkg;

    typedef enum logic [1:0] {
        DB_LOW,
        DB_WAIT_HIGH,
        DB_HIGH,
        DB_WAIT_LOW
    } db_state_t;

    localparam int BTN_MODE    = 0;
    localparam int BTN_SCALE   = 1;
    localparam int BTN_HEX_BCD = 2;
    localparam int BTN_ADC_SEL = 3;

endpackage

// File: rtl/debounce_channel.sv
// Single-button synchroniser plus stability-counter debouncer with edge pulses.
// Latency: db/rise/fall move SYNC_STAGES+1+STABLE_CYCLES edges after a held raw change.
// Backpressure: none; free-running level filter, pulses are one cycle wide.
module debounce_channel
    import menu_pkg::*;
#(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DB_LOW;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any return of s to the settled level abandons the count; cnt is zero outside WAIT states.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            DB_LOW: begin
                if (s) begin
                    state_d = DB_WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            DB_WAIT_HIGH: begin
                if (!s) begin
                    state_d = DB_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_HIGH;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DB_HIGH: begin
                if (!s) begin
                    state_d = DB_WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            DB_WAIT_LOW: begin
                if (s) begin
                    state_d = DB_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_LOW;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = DB_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign db   = db_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/button_debounce_bank.sv
// Bank of independent push-button debouncers feeding the menu FSM.
// Latency: SYNC_STAGES+1+STABLE_CYCLES edges from a held raw change to btn_db/btn_rise/btn_fall.
// Backpressure: none; all channels update in parallel with no priority.
module button_debounce_bank
    import menu_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise,
    output logic [N_BTN-1:0] btn_fall
);

    if (STABLE_CYCLES < 2) begin : g_bad_stable
        $error("button_debounce_bank: STABLE_CYCLES must be >= 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("button_debounce_bank: SYNC_STAGES must be >= 2");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (btn_raw[i]),
            .db    (btn_db[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i])
        );
    end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank: stimulus queues expected edge events,
// a negedge monitor pops and compares them and checks levels on every other cycle.
module tb_button_debounce_bank;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_db;
    logic [3:0] btn_rise;
    logic [3:0] btn_fall;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         cyc;
        logic [3:0] db;
        logic [3:0] rise;
        logic [3:0] fall;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] cur_db = 4'h0;

    button_debounce_bank #(
        .N_BTN         (4),
        .STABLE_CYCLES (4),
        .SYNC_STAGES   (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_db   (btn_db),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Raw changes made right after edge k are first sampled on edge k+1, so outputs move on edge k+7.
    task automatic expect_at7(input logic [3:0] db, input logic [3:0] rise, input logic [3:0] fall);
        exp_t e;
        e.cyc  = cyc + 7;
        e.db   = db;
        e.rise = rise;
        e.fall = fall;
        exp_q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pulses are the DUT's "output valid"; every pulse must match the next queued event.
    always @(negedge clk) begin
        if (!reset) begin
            chk("reset_db",   btn_db,   0);
            chk("reset_rise", btn_rise, 0);
            chk("reset_fall", btn_fall, 0);
            cur_db = 4'h0;
        end else if ((btn_rise | btn_fall) != 4'h0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {btn_rise, btn_fall}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_cycle", cyc,      e.cyc);
                chk("event_db",    btn_db,   e.db);
                chk("event_rise",  btn_rise, e.rise);
                chk("event_fall",  btn_fall, e.fall);
                cur_db = e.db;
            end
        end else begin
            chk("level_db", btn_db, cur_db);
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                chk("missed_event_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset   = 1'b0;
        btn_raw = 4'hF;

        // Held through reset: qualified normally after release.
        step(6);
        reset = 1'b1;
        expect_at7(4'hF, 4'hF, 4'h0);
        step(12);
        btn_raw = 4'h0;
        expect_at7(4'h0, 4'h0, 4'hF);
        step(12);

        // Clean press/release on channel 0.
        btn_raw = 4'h1;
        expect_at7(4'h1, 4'h1, 4'h0);
        step(12);
        btn_raw = 4'h0;
        expect_at7(4'h0, 4'h0, 4'h1);
        step(12);

        // Bounce on channel 1: 3 high, 1 low, then held high.
        btn_raw = 4'h2;
        step(3);
        btn_raw = 4'h0;
        step(1);
        btn_raw = 4'h2;
        expect_at7(4'h2, 4'h2, 4'h0);
        step(12);
        btn_raw = 4'h0;
        expect_at7(4'h0, 4'h0, 4'h2);
        step(12);

        // Isolated 3-cycle glitch on channel 1 must never surface.
        btn_raw = 4'h2;
        step(3);
        btn_raw = 4'h0;
        step(15);

        // Simultaneous channels 1 and 3.
        btn_raw = 4'hA;
        expect_at7(4'hA, 4'hA, 4'h0);
        step(12);
        btn_raw = 4'h0;
        expect_at7(4'h0, 4'h0, 4'hA);
        step(12);

        // Reset mid-qualification of channel 2 while channel 0 is already accepted high.
        btn_raw = 4'h1;
        expect_at7(4'h1, 4'h1, 4'h0);
        step(12);
        btn_raw = 4'h5;
        step(4);
        reset = 1'b0;
        #1;
        chk("async_reset_db",   btn_db,   0);
        chk("async_reset_rise", btn_rise, 0);
        chk("async_reset_fall", btn_fall, 0);
        step(3);
        reset = 1'b1;
        expect_at7(4'h5, 4'h5, 4'h0);
        step(12);
        btn_raw = 4'h0;
        expect_at7(4'h0, 4'h0, 4'h5);
        step(12);

        // Long hold on channel 3: one rise, steady level, one fall on release.
        btn_raw = 4'h8;
        expect_at7(4'h8, 4'h8, 4'h0);
        step(1000);
        btn_raw = 4'h0;
        expect_at7(4'h0, 4'h0, 4'h8);
        step(12);

        chk("events_outstanding", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
